key_nav: RTL

Downstream consumer of the button debouncer's one-cycle key codes. It queues key events in a small FIFO and moves a cursor over a COLS x ROWS grid. On a select key it presents the cursor position through a valid/ready handshake. It sits between the debounced key decoder and game/menu logic, so no key press is lost while that logic is busy.

---
 rtl/key_pkg.sv | 25 ++
 rtl/key_fifo.sv | 51 +++++
 rtl/key_nav.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key navigation block: key codes, FSM state
// encoding and a small helper that says whether a code is a real event.
package key_pkg;

    typedef logic [2:0] key_code_t;

    localparam key_code_t KEY_NONE  = 3'd0;
    localparam key_code_t KEY_UP    = 3'd1;
    localparam key_code_t KEY_LEFT  = 3'd2;
    localparam key_code_t KEY_RIGHT = 3'd3;
    localparam key_code_t KEY_DOWN  = 3'd4;
    localparam key_code_t KEY_SEL   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_APPLY    = 2'd1,
        ST_SEL_WAIT = 2'd2
    } nav_state_t;

    // Codes 6 and 7 are treated like "no key": never queued, never overflow.
    function automatic logic key_is_valid(input key_code_t k);
        return (k >= KEY_UP) && (k <= KEY_SEL);
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO for 3-bit key codes. Pointers carry one extra wrap
// bit so full and empty are distinguishable without a separate counter.
module key_fifo
    import key_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  key_code_t din,
    output key_code_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0] wr_ptr_q, rd_ptr_q;
    key_code_t   mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push while full is still legal.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; reset flushes the queue by re-aligning both pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage needs no reset: contents are only visible behind the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/key_nav.sv
// Key navigation: queues debounced key events and moves a cursor over a
// COLS x ROWS grid; select presents the position through valid/ready.
// Define KEY_NAV_WRAP_EN for toroidal wrap at the grid edges; by default
// the cursor saturates.
//
// state    | meaning
// ---------+------------------------------------------------
// IDLE     | waiting for a queued event; pops head when present
// APPLY    | acting on the popped code (move or capture select)
// SEL_WAIT | select result pending until consumer takes it
module key_nav
    import key_pkg::*;
#(
    parameter int  COLS       = 8,
    parameter int  ROWS       = 8,
    parameter int  FIFO_DEPTH = 4,
    localparam int XW         = $clog2(COLS),
    localparam int YW         = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    key_in,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic          sel_valid,
    output logic [XW-1:0] sel_x,
    output logic [YW-1:0] sel_y,
    input  logic          sel_ready,
    output logic          overflow
);

    localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);
    localparam logic [XW-1:0] X_ONE = XW'(1);
    localparam logic [YW-1:0] Y_ONE = YW'(1);

    nav_state_t    state_q;
    key_code_t     code_q;
    logic [XW-1:0] cur_x_q, cur_x_d, sel_x_q;
    logic [YW-1:0] cur_y_q, cur_y_d, sel_y_q;
    logic          sel_valid_q, overflow_q;

    logic          key_valid, fifo_pop, fifo_full, fifo_empty;
    key_code_t     fifo_dout;

    assign key_valid = key_is_valid(key_in);
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

    key_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (key_valid),
        .pop   (fifo_pop),
        .din   (key_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next cursor position for the code held in code_q, edge policy by build.
    always_comb begin
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        case (code_q)
            KEY_UP: begin
                if (cur_y_q != '0) cur_y_d = cur_y_q - Y_ONE;
`ifdef KEY_NAV_WRAP_EN
                else               cur_y_d = Y_MAX;
`else
                else               cur_y_d = cur_y_q;
`endif
            end
            KEY_DOWN: begin
                if (cur_y_q != Y_MAX) cur_y_d = cur_y_q + Y_ONE;
`ifdef KEY_NAV_WRAP_EN
                else                  cur_y_d = '0;
`else
                else                  cur_y_d = cur_y_q;
`endif
            end
            KEY_LEFT: begin
                if (cur_x_q != '0) cur_x_d = cur_x_q - X_ONE;
`ifdef KEY_NAV_WRAP_EN
                else               cur_x_d = X_MAX;
`else
                else               cur_x_d = cur_x_q;
`endif
            end
            KEY_RIGHT: begin
                if (cur_x_q != X_MAX) cur_x_d = cur_x_q + X_ONE;
`ifdef KEY_NAV_WRAP_EN
                else                  cur_x_d = '0;
`else
                else                  cur_x_d = cur_x_q;
`endif
            end
            default: ;
        endcase
    end

    // Navigation FSM with registered cursor, select result and overflow pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            code_q      <= KEY_NONE;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            sel_x_q     <= '0;
            sel_y_q     <= '0;
            sel_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            overflow_q <= key_valid && fifo_full && !fifo_pop;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        code_q  <= fifo_dout;
                        state_q <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (code_q == KEY_SEL) begin
                        sel_x_q     <= cur_x_q;
                        sel_y_q     <= cur_y_q;
                        sel_valid_q <= 1'b1;
                        state_q     <= ST_SEL_WAIT;
                    end else begin
                        cur_x_q <= cur_x_d;
                        cur_y_q <= cur_y_d;
                        state_q <= ST_IDLE;
                    end
                end
                ST_SEL_WAIT: begin
                    if (sel_valid_q && sel_ready) begin
                        sel_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cur_x     = cur_x_q;
    assign cur_y     = cur_y_q;
    assign sel_x     = sel_x_q;
    assign sel_y     = sel_y_q;
    assign sel_valid = sel_valid_q;
    assign overflow  = overflow_q;

endmodule
